// File: rtl/bitrev_reorder.sv
// Reorders four-lane bit-reversed FFT output into natural frequency order.
// Two ping-pong banks of N words: one bank fills at bit-reversed addresses while the
// other drains in linear order. A drain can start on the same edge that completes its
// fill, so reads are forwarded from the write port when the addresses coincide.
module bitrev_reorder #(
    parameter int unsigned NBITS = 30,
    parameter int unsigned N     = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NBITS-1:0] reoIn0_up,
    input  logic [NBITS-1:0] reoIn0_down,
    input  logic [NBITS-1:0] reoIn1_up,
    input  logic [NBITS-1:0] reoIn1_down,
    input  logic             in_valid,
    input  logic             in_sof,
    output logic [NBITS-1:0] reoOut0_up,
    output logic [NBITS-1:0] reoOut0_down,
    output logic [NBITS-1:0] reoOut1_up,
    output logic [NBITS-1:0] reoOut1_down,
    output logic             out_valid,
    output logic             out_sof,
    output logic             frame_err
);

    localparam int unsigned AW = $clog2(N);
    localparam int unsigned BW = AW - 2;
    localparam logic [BW-1:0] LastBeat = BW'(N / 4 - 1);

    typedef enum logic {WrIdle, WrFill} wr_state_e;
    typedef enum logic {RdIdle, RdDrain} rd_state_e;

    function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] a);
        logic [AW-1:0] r;
        for (int i = 0; i < int'(AW); i++) begin
            r[i] = a[int'(AW) - 1 - i];
        end
        return r;
    endfunction

    // Input lanes in index order (lane l carries input index 4c + l)
    logic [NBITS-1:0] in_lane [4];
    assign in_lane[0] = reoIn0_up;
    assign in_lane[1] = reoIn0_down;
    assign in_lane[2] = reoIn1_up;
    assign in_lane[3] = reoIn1_down;

    // Storage: two banks, deliberately not reset
    logic [NBITS-1:0] mem_q [2][N];

    // Write side state
    wr_state_e         wr_state_q, wr_state_d;
    logic [BW-1:0]     wr_beat_q, wr_beat_d;
    logic              wr_bank_q, wr_bank_d;
    logic              wr_en;
    logic [BW-1:0]     wr_beat_sel;
    logic              fill_done;
    logic              abort;
    logic [AW-1:0]     wr_addr [4];

    // Read side state
    rd_state_e         rd_state_q, rd_state_d;
    logic [BW-1:0]     rd_beat_q, rd_beat_d;
    logic              rd_bank_q, rd_bank_d;
    logic [1:0]        full_q, full_d;
    logic              rd_en;
    logic              rd_bank_sel;
    logic [BW-1:0]     rd_beat_sel;
    logic [AW-1:0]     rd_addr [4];
    logic [NBITS-1:0]  rd_data [4];

    // Registered outputs
    logic [NBITS-1:0]  out_lane_q [4];
    logic              out_valid_q;
    logic              out_sof_q;
    logic              frame_err_q;

    // Write FSM next state: accept beats, restart on sof, complete frame on last beat
    always_comb begin
        wr_state_d  = wr_state_q;
        wr_beat_d   = wr_beat_q;
        wr_bank_d   = wr_bank_q;
        wr_en       = 1'b0;
        wr_beat_sel = wr_beat_q;
        fill_done   = 1'b0;
        abort       = 1'b0;
        if (in_valid && in_sof) begin
            wr_en       = 1'b1;
            wr_beat_sel = '0;
            // A partial frame is in progress whenever we are in WrFill
            abort       = (wr_state_q == WrFill);
        end else if (in_valid && (wr_state_q == WrFill)) begin
            wr_en = 1'b1;
        end
        if (wr_en) begin
            if (wr_beat_sel == LastBeat) begin
                fill_done  = 1'b1;
                wr_state_d = WrIdle;
                wr_beat_d  = '0;
                wr_bank_d  = ~wr_bank_q;
            end else begin
                wr_state_d = WrFill;
                wr_beat_d  = wr_beat_sel + BW'(1);
            end
        end
    end

    // Write addresses: input index 4c + l lands at its bit-reversed address
    always_comb begin
        for (int unsigned w = 0; w < 4; w++) begin
            wr_addr[w] = bitrev({wr_beat_sel, 2'(w)});
        end
    end

    // Write FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_state_q <= WrIdle;
            wr_beat_q  <= '0;
            wr_bank_q  <= 1'b0;
        end else begin
            wr_state_q <= wr_state_d;
            wr_beat_q  <= wr_beat_d;
            wr_bank_q  <= wr_bank_d;
        end
    end

    // Memory write port, four words per accepted beat
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int unsigned w = 0; w < 4; w++) begin
                mem_q[wr_bank_q][wr_addr[w]] <= in_lane[w];
            end
        end
    end

    // Read FSM next state: start on a completed fill, chain into a pending full bank
    always_comb begin
        rd_state_d  = rd_state_q;
        rd_beat_d   = rd_beat_q;
        rd_bank_d   = rd_bank_q;
        full_d      = full_q;
        rd_en       = 1'b0;
        rd_bank_sel = rd_bank_q;
        rd_beat_sel = rd_beat_q;
        if (fill_done) begin
            full_d[wr_bank_q] = 1'b1;
        end
        unique case (rd_state_q)
            RdIdle: begin
                if (fill_done) begin
                    // First beat is read on the same edge that writes the final beat
                    rd_en       = 1'b1;
                    rd_bank_sel = wr_bank_q;
                    rd_beat_sel = '0;
                    rd_state_d  = RdDrain;
                    rd_bank_d   = wr_bank_q;
                    rd_beat_d   = BW'(1);
                end
            end
            RdDrain: begin
                rd_en = 1'b1;
                if (rd_beat_q == LastBeat) begin
                    full_d[rd_bank_q] = 1'b0;
                    rd_beat_d         = '0;
                    if (full_d[~rd_bank_q]) begin
                        rd_bank_d = ~rd_bank_q;
                    end else begin
                        rd_state_d = RdIdle;
                    end
                end else begin
                    rd_beat_d = rd_beat_q + BW'(1);
                end
            end
            default: rd_state_d = RdIdle;
        endcase
    end

    // Read FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_state_q <= RdIdle;
            rd_beat_q  <= '0;
            rd_bank_q  <= 1'b0;
            full_q     <= '0;
        end else begin
            rd_state_q <= rd_state_d;
            rd_beat_q  <= rd_beat_d;
            rd_bank_q  <= rd_bank_d;
            full_q     <= full_d;
        end
    end

    // Linear read of four words, forwarding any word being written this cycle
    always_comb begin
        for (int unsigned l = 0; l < 4; l++) begin
            rd_addr[l] = {rd_beat_sel, 2'(l)};
            rd_data[l] = mem_q[rd_bank_sel][rd_addr[l]];
            for (int unsigned w = 0; w < 4; w++) begin
                if (wr_en && (wr_bank_q == rd_bank_sel) && (wr_addr[w] == rd_addr[l])) begin
                    rd_data[l] = in_lane[w];
                end
            end
        end
    end

    // Output registers; lanes hold their last value between drains
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_sof_q   <= 1'b0;
            frame_err_q <= 1'b0;
            for (int unsigned l = 0; l < 4; l++) begin
                out_lane_q[l] <= '0;
            end
        end else begin
            out_valid_q <= rd_en;
            out_sof_q   <= rd_en && (rd_beat_sel == '0);
            frame_err_q <= abort;
            if (rd_en) begin
                for (int unsigned l = 0; l < 4; l++) begin
                    out_lane_q[l] <= rd_data[l];
                end
            end
        end
    end

    assign reoOut0_up   = out_lane_q[0];
    assign reoOut0_down = out_lane_q[1];
    assign reoOut1_up   = out_lane_q[2];
    assign reoOut1_down = out_lane_q[3];
    assign out_valid    = out_valid_q;
    assign out_sof      = out_sof_q;
    assign frame_err    = frame_err_q;

endmodule

// File: tb/tb_bitrev_reorder.sv
// Directed bench for bitrev_reorder with N=32: single frame, back-to-back frames,
// gapped input, sof abort, reset mid-drain and sof-less beats.
module tb_bitrev_reorder;

    localparam int NB = 30;
    localparam int NN = 32;

    localparam logic [NB-1:0] BaseA = 30'h2AAAA000;
    localparam logic [NB-1:0] BaseB = 30'h15555500;
    localparam logic [NB-1:0] BaseC = 30'h3FFFFFC0;
    localparam logic [NB-1:0] BaseD = 30'h00F0F000;
    localparam logic [NB-1:0] BaseG = 30'h12345000;

    logic          clk = 1'b0;
    logic          rst;
    logic [NB-1:0] in0u, in0d, in1u, in1d;
    logic          in_valid, in_sof;
    logic [NB-1:0] o0u, o0d, o1u, o1d;
    logic          out_valid, out_sof, frame_err;

    always #5 clk = ~clk;

    bitrev_reorder #(.NBITS(NB), .N(NN)) dut (
        .clk          (clk),
        .rst          (rst),
        .reoIn0_up    (in0u),
        .reoIn0_down  (in0d),
        .reoIn1_up    (in1u),
        .reoIn1_down  (in1d),
        .in_valid     (in_valid),
        .in_sof       (in_sof),
        .reoOut0_up   (o0u),
        .reoOut0_down (o0d),
        .reoOut1_up   (o1u),
        .reoOut1_down (o1d),
        .out_valid    (out_valid),
        .out_sof      (out_sof),
        .frame_err    (frame_err)
    );

    typedef struct packed {
        logic [3:0][NB-1:0] d;
        logic               sof;
        logic [31:0]        stamp;
    } beat_t;

    int unsigned cyc      = 0;
    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned err_cnt  = 0;
    logic [31:0] err_stamp = '0;
    beat_t       cap_q[$];

    // Capture every valid output beat and frame_err pulse, stamped with the edge count
    initial begin
        forever begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                beat_t b;
                b.d[0]  = o0u;
                b.d[1]  = o0d;
                b.d[2]  = o1u;
                b.d[3]  = o1d;
                b.sof   = out_sof;
                b.stamp = cyc;
                cap_q.push_back(b);
            end
            if (frame_err === 1'b1) begin
                err_cnt   = err_cnt + 1;
                err_stamp = cyc;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int unsigned brev5(input int unsigned a);
        int unsigned r = 0;
        for (int i = 0; i < 5; i++) begin
            r = r | (((a >> i) & 1) << (4 - i));
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        cyc = cyc + 1;
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        in_sof   = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic drive(input logic v, input logic s, input logic [NB-1:0] base, input int c);
        in_valid = v;
        in_sof   = s;
        in0u     = base + NB'(4 * c);
        in0d     = base + NB'(4 * c + 1);
        in1u     = base + NB'(4 * c + 2);
        in1d     = base + NB'(4 * c + 3);
        tick();
    endtask

    // Word for input index k is base + k; returns the edge count of the final beat
    task automatic send_frame(input logic [NB-1:0] base, input bit gap, output int unsigned e);
        for (int c = 0; c < 8; c++) begin
            if (gap && c > 0) idle(1);
            drive(1'b1, c == 0, base, c);
        end
        e        = cyc;
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic check_drain(input string tag, input logic [NB-1:0] base, input int unsigned e,
                               input int unsigned idx);
        for (int unsigned c = 0; c < 8; c++) begin
            if (idx + c < cap_q.size()) begin
                check_eq($sformatf("%s b%0d stamp", tag, c), cap_q[idx+c].stamp, e + c);
                check_eq($sformatf("%s b%0d sof", tag, c), cap_q[idx+c].sof, (c == 0));
                for (int unsigned l = 0; l < 4; l++) begin
                    check_eq($sformatf("%s b%0d lane%0d", tag, c, l), cap_q[idx+c].d[l],
                             base + NB'(brev5(4 * c + l)));
                end
            end else begin
                check_eq($sformatf("%s b%0d present", tag, c), cap_q.size(), idx + c + 1);
            end
        end
    endtask

    int unsigned   e, ea, eb;
    logic [NB-1:0] hand [3][4];
    int            hand_beat [3];

    initial begin
        hand      = '{'{0, 16, 8, 24}, '{4, 20, 12, 28}, '{7, 23, 15, 31}};
        hand_beat = '{0, 1, 7};
        rst      = 1'b1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        in0u = '0; in0d = '0; in1u = '0; in1d = '0;

        // Reset state
        repeat (3) tick();
        check_eq("rst out_valid", out_valid, 0);
        check_eq("rst out_sof", out_sof, 0);
        check_eq("rst frame_err", frame_err, 0);
        check_eq("rst lane0", o0u, 0);
        check_eq("rst lane3", o1d, 0);
        rst = 1'b0;
        idle(2);

        // Single contiguous frame, word = k
        cap_q.delete();
        err_cnt = 0;
        send_frame('0, 1'b0, e);
        idle(12);
        check_eq("s1 beats", cap_q.size(), 8);
        check_drain("s1", '0, e, 0);
        for (int i = 0; i < 3; i++) begin
            if (cap_q.size() > hand_beat[i]) begin
                for (int l = 0; l < 4; l++) begin
                    check_eq($sformatf("s1 hand b%0d lane%0d", hand_beat[i], l),
                             cap_q[hand_beat[i]].d[l], hand[i][l]);
                end
            end
        end
        check_eq("s1 idle valid", out_valid, 0);
        check_eq("s1 hold lane0", o0u, 7);
        check_eq("s1 hold lane1", o0d, 23);
        check_eq("s1 err", err_cnt, 0);

        // Back-to-back frames A then B
        cap_q.delete();
        send_frame(BaseA, 1'b0, ea);
        send_frame(BaseB, 1'b0, eb);
        idle(12);
        check_eq("s2 beats", cap_q.size(), 16);
        check_drain("s2a", BaseA, ea, 0);
        check_drain("s2b", BaseB, ea + 8, 8);

        // in_valid low on alternate cycles
        cap_q.delete();
        send_frame(BaseC, 1'b1, e);
        idle(12);
        check_eq("s3 beats", cap_q.size(), 8);
        check_drain("s3", BaseC, e, 0);

        // sof re-asserted at beat 5
        cap_q.delete();
        err_cnt = 0;
        for (int c = 0; c < 5; c++) drive(1'b1, c == 0, BaseG, c);
        send_frame(BaseD, 1'b0, e);
        idle(12);
        check_eq("s4 err count", err_cnt, 1);
        check_eq("s4 err stamp", err_stamp, e - 7);
        check_eq("s4 beats", cap_q.size(), 8);
        check_drain("s4", BaseD, e, 0);

        // Reset during drain beat 3
        cap_q.delete();
        send_frame(BaseA, 1'b0, e);
        idle(3);
        check_eq("s5 beat3 valid", out_valid, 1);
        rst = 1'b1;
        tick();
        check_eq("s5 rst valid", out_valid, 0);
        check_eq("s5 rst sof", out_sof, 0);
        check_eq("s5 rst lane0", o0u, 0);
        rst = 1'b0;
        idle(12);
        check_eq("s5 beats", cap_q.size(), 4);
        send_frame(BaseB, 1'b0, e);
        idle(12);
        check_eq("s5 beats after", cap_q.size(), 12);
        check_drain("s5new", BaseB, e, 4);

        // Valid beats without sof after reset
        rst = 1'b1;
        tick();
        rst = 1'b0;
        cap_q.delete();
        err_cnt = 0;
        for (int c = 0; c < 10; c++) drive(1'b1, 1'b0, BaseA, c % 8);
        idle(12);
        check_eq("s6 beats", cap_q.size(), 0);
        check_eq("s6 err", err_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
